// File: rtl/div_unit_pkg.sv
// Shared encodings for the iterative divider: FSM states, start/ready levels
// and register-bus widths.
package div_unit_pkg;

    localparam int RegisterBus       = 32;
    localparam int DoubleRegisterBus = 64;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;
    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;

endpackage

// File: rtl/div_unit.sv
// Radix-2 restoring divider, one trial subtraction per cycle, {rem, quo} out.
// Define DIV_ZERO_DETECT_EN to short-circuit a zero divisor to a zero result.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int DIV_W = RegisterBus
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div_i,
    input  logic [DIV_W-1:0]   opdata1_i,
    input  logic [DIV_W-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*DIV_W-1:0] result_o,
    output logic               ready_o
);

    localparam int CNT_W = $clog2(DIV_W) + 1;

    div_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*DIV_W:0]   work_q, work_d;
    logic [DIV_W-1:0]   divisor_q, divisor_d;
    logic               signed_q, signed_d;
    logic               neg_a_q, neg_a_d;
    logic               neg_b_q, neg_b_d;
    logic [2*DIV_W-1:0] result_q, result_d;
    logic               ready_q, ready_d;

    logic [DIV_W:0]     diff_s;
    logic [DIV_W-1:0]   mag_a_s;
    logic [DIV_W-1:0]   mag_b_s;
    logic [DIV_W-1:0]   quo_s;
    logic [DIV_W-1:0]   rem_s;

    // Next-state, datapath and output computation.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        work_d    = work_q;
        divisor_d = divisor_q;
        signed_d  = signed_q;
        neg_a_d   = neg_a_q;
        neg_b_d   = neg_b_q;
        result_d  = result_q;
        ready_d   = ready_q;

        mag_a_s = (signed_div_i && opdata1_i[DIV_W-1]) ? -opdata1_i : opdata1_i;
        mag_b_s = (signed_div_i && opdata2_i[DIV_W-1]) ? -opdata2_i : opdata2_i;
        // Zero-extended so the top bit of the difference is the borrow.
        diff_s  = {1'b0, work_q[2*DIV_W-1:DIV_W]} - {1'b0, divisor_q};
        quo_s   = (signed_q && (neg_a_q ^ neg_b_q)) ? -work_q[DIV_W-1:0] : work_q[DIV_W-1:0];
        rem_s   = (signed_q && neg_a_q) ? -work_q[2*DIV_W:DIV_W+1] : work_q[2*DIV_W:DIV_W+1];

        case (state_q)
            DivFree: begin
                if (start_i == DivStart && !annul_i) begin
                    signed_d  = signed_div_i;
                    neg_a_d   = signed_div_i & opdata1_i[DIV_W-1];
                    neg_b_d   = signed_div_i & opdata2_i[DIV_W-1];
                    divisor_d = mag_b_s;
                    cnt_d     = {CNT_W{1'b0}};
                    work_d    = {{DIV_W{1'b0}}, mag_a_s, 1'b0};
`ifdef DIV_ZERO_DETECT_EN
                    if (opdata2_i == {DIV_W{1'b0}}) begin
                        state_d = DivByZero;
                    end else begin
                        state_d = DivOn;
                    end
`else
                    state_d = DivOn;
`endif
                end else begin
                    state_d = DivFree;
                end
            end
`ifdef DIV_ZERO_DETECT_EN
            DivByZero: begin
                state_d  = DivEnd;
                result_d = {(2*DIV_W){1'b0}};
                ready_d  = DivResultReady;
            end
`endif
            DivOn: begin
                if (annul_i || start_i == DivStop) begin
                    state_d  = DivFree;
                    result_d = {(2*DIV_W){1'b0}};
                    ready_d  = DivResultNotReady;
                end else if (cnt_q == CNT_W'(DIV_W)) begin
                    state_d  = DivEnd;
                    result_d = {rem_s, quo_s};
                    ready_d  = DivResultReady;
                end else begin
                    if (diff_s[DIV_W]) begin
                        work_d = {work_q[2*DIV_W-1:0], 1'b0};
                    end else begin
                        work_d = {diff_s[DIV_W-1:0], work_q[DIV_W-1:0], 1'b1};
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DivEnd: begin
                if (start_i == DivStop) begin
                    state_d  = DivFree;
                    result_d = {(2*DIV_W){1'b0}};
                    ready_d  = DivResultNotReady;
                end else begin
                    state_d = DivEnd;
                end
            end
            default: begin
                state_d  = DivFree;
                result_d = {(2*DIV_W){1'b0}};
                ready_d  = DivResultNotReady;
            end
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= DivFree;
            cnt_q     <= {CNT_W{1'b0}};
            work_q    <= {(2*DIV_W+1){1'b0}};
            divisor_q <= {DIV_W{1'b0}};
            signed_q  <= 1'b0;
            neg_a_q   <= 1'b0;
            neg_b_q   <= 1'b0;
            result_q  <= {(2*DIV_W){1'b0}};
            ready_q   <= DivResultNotReady;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            work_q    <= work_d;
            divisor_q <= divisor_d;
            signed_q  <= signed_d;
            neg_a_q   <= neg_a_d;
            neg_b_q   <= neg_b_d;
            result_q  <= result_d;
            ready_q   <= ready_d;
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: directed divides push expected {rem, quo} and
// latency; a negedge monitor checks results, hold behaviour and idle zeros.
module tb_div_unit;

    logic        clk;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    typedef struct {
        logic [63:0] res;
        int          lat;
        int          issue;
    } exp_t;

    exp_t exp_q[$];
    int   cyc;
    int   n_cmp;
    int   n_bad;

    div_unit #(.DIV_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops on ready rise, checks hold while ready, zero result otherwise.
    initial begin : monitor
        exp_t        e;
        logic        ready_seen;
        logic [63:0] cur;
        ready_seen = 1'b0;
        cur        = 64'h0;
        forever begin
            @(negedge clk);
            if (rst) begin
                ready_seen = 1'b0;
            end else if (ready_o && !ready_seen) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_ready: ready rose with result %h, none expected", result_o);
                end else begin
                    e   = exp_q.pop_front();
                    cur = e.res;
                    if (result_o !== e.res) begin
                        n_bad++;
                        $display("FAIL result: got %h expected %h", result_o, e.res);
                    end
                    n_cmp++;
                    if (cyc - e.issue != e.lat) begin
                        n_bad++;
                        $display("FAIL latency: got %0d expected %0d", cyc - e.issue, e.lat);
                    end
                end
                ready_seen = 1'b1;
            end else if (ready_o) begin
                n_cmp++;
                if (result_o !== cur) begin
                    n_bad++;
                    $display("FAIL result_hold: got %h expected %h", result_o, cur);
                end
            end else begin
                n_cmp++;
                if (result_o !== 64'h0) begin
                    n_bad++;
                    $display("FAIL idle_result: got %h expected 0", result_o);
                end
                ready_seen = 1'b0;
            end
        end
    end

    task automatic do_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp_res, input int lat, input int hold);
        exp_t e;
        logic got;
        @(negedge clk);
        signed_div_i = s;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        e.res   = exp_res;
        e.lat   = lat;
        e.issue = cyc;
        exp_q.push_back(e);
        got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            if (i == 0) begin
                opdata1_i = $urandom;
                opdata2_i = $urandom;
                signed_div_i = ~s;
            end
            if (ready_o) got = 1'b1;
        end
        if (!got) begin
            n_cmp++;
            n_bad++;
            $display("FAIL ready_timeout: ready still 0 after 60 cycles, expected result %h", exp_res);
            if (exp_q.size() != 0) void'(exp_q.pop_front());
        end
        repeat (hold) @(negedge clk);
        start_i = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic check_idle(input string name);
        n_cmp++;
        if (ready_o !== 1'b0 || result_o !== 64'h0) begin
            n_bad++;
            $display("FAIL %s: got ready=%b result=%h expected ready=0 result=0", name, ready_o, result_o);
        end
    endtask

    initial begin
        cyc          = 0;
        n_cmp        = 0;
        n_bad        = 0;
        rst          = 1'b1;
        signed_div_i = 1'b0;
        opdata1_i    = 32'h0;
        opdata2_i    = 32'h0;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        repeat (3) @(negedge clk);
        check_idle("reset_state");
        rst = 1'b0;
        @(negedge clk);

        do_div(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 34, 3);
        do_div(1'b1, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 34, 0);
        do_div(1'b1, 32'd7, 32'hFFFFFFFE, {32'h00000001, 32'hFFFFFFFD}, 34, 1);
        do_div(1'b1, 32'h80000000, 32'hFFFFFFFF, {32'h0, 32'h80000000}, 34, 0);
`ifdef DIV_ZERO_DETECT_EN
        do_div(1'b0, 32'd5, 32'd0, 64'h0, 2, 2);
        do_div(1'b1, 32'hFFFFFFF7, 32'd0, 64'h0, 2, 0);
`else
        do_div(1'b0, 32'd5, 32'd0, {32'd5, 32'hFFFFFFFF}, 34, 2);
        do_div(1'b1, 32'hFFFFFFF7, 32'd0, {32'hFFFFFFF7, 32'h00000001}, 34, 0);
`endif

        // Annul partway through: the aborted divide must never report.
        @(negedge clk);
        signed_div_i = 1'b0;
        opdata1_i    = 32'd1000;
        opdata2_i    = 32'd3;
        start_i      = 1'b1;
        repeat (11) @(negedge clk);
        annul_i = 1'b1;
        @(negedge clk);
        annul_i = 1'b0;
        start_i = 1'b0;
        repeat (40) @(negedge clk);
        check_idle("annul_no_ready");
        do_div(1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 34, 0);

        // Asynchronous reset in the middle of an iteration run.
        @(negedge clk);
        signed_div_i = 1'b0;
        opdata1_i    = 32'h0000FFFF;
        opdata2_i    = 32'd1;
        start_i      = 1'b1;
        repeat (21) @(negedge clk);
        #2 rst = 1'b1;
        #1 check_idle("reset_mid_op");
        start_i = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_idle("after_reset");
        do_div(1'b1, 32'd15, 32'd4, {32'd3, 32'd3}, 34, 0);

        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
